// File: rtl/stream_mux_rr.sv
// Round-robin packet multiplexer: N_CH valid/ready streams merged onto one
// registered output, with the grant locked until the granted packet's last beat.
module stream_mux_rr #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e state_q, state_d;

  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic [SEL_W-1:0]  hi_idx, lo_idx, winner;
  logic              hi_hit;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  // Lowest requester above ptr wins; otherwise lowest overall (the wrap).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = SEL_W'(i);
        if (i > int'(ptr_q)) begin
          hi_idx = SEL_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
    winner = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED) begin
      in_ready[grant_q] = !out_valid_q || out_ready;
    end
  end

  assign accept   = in_valid[grant_q] && in_ready[grant_q];
  assign sel_data = in_data[int'(grant_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_last_d  = in_last[grant_q];
          out_ch_d    = grant_q;
          if (in_last[grant_q]) begin
            ptr_d   = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: queued sources per channel, output beat
// log, and hand-computed expected beat orders and cycle spacings.
module tb_stream_mux_rr;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [2:0]   out_ch;
  logic         out_ready;

  stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0]   srcq [N][$];
  logic [8:0]   ent;
  logic [N-1:0] pend;
  int acc_cnt [N];
  int acc_cyc [N];
  int oq_ch[$];
  int oq_data[$];
  int oq_last[$];
  int oq_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic l);
    srcq[ch].push_back({l, d});
  endtask

  task automatic clear_logs();
    oq_ch.delete();
    oq_data.delete();
    oq_last.delete();
    oq_cyc.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (oq_ch.size() < n && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    repeat (6) @(negedge clk);
    #2;
    chk({tag, " beats"}, oq_ch.size(), n);
  endtask

  task automatic chk_beat(input string tag, input int i, input int ch,
                          input int d, input int l);
    int gc, gd, gl;
    gc = (i < oq_ch.size()) ? oq_ch[i] : -1;
    gd = (i < oq_ch.size()) ? oq_data[i] : -1;
    gl = (i < oq_ch.size()) ? oq_last[i] : -1;
    chk($sformatf("%s b%0d ch", tag, i), gc, ch);
    chk($sformatf("%s b%0d data", tag, i), gd, d);
    chk($sformatf("%s b%0d last", tag, i), gl, l);
  endtask

  function automatic int gap(input int i);
    if (i + 1 < oq_cyc.size()) return oq_cyc[i+1] - oq_cyc[i];
    return -1;
  endfunction

  // Source model: accept is sampled mid-cycle, committed after the edge.
  initial begin
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0;
      acc_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      pend = in_valid & in_ready;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if (acc_cnt[i] == 0) acc_cyc[i] = cyc;
          acc_cnt[i]++;
        end
      end
      if (out_valid && out_ready) begin
        oq_ch.push_back(int'(out_ch));
        oq_data.push_back(int'(out_data));
        oq_last.push_back(int'(out_last));
        oq_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && rst_n && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
        end
        if (srcq[i].size() > 0) begin
          ent = srcq[i][0];
          in_valid[i] = 1'b1;
          in_data[i*W +: W] = ent[7:0];
          in_last[i] = ent[8];
        end else begin
          in_valid[i] = 1'b0;
          in_data[i*W +: W] = '0;
          in_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);

    // 1: reset with every channel requesting
    repeat (3) @(negedge clk);
    #2;
    chk("t1 rst in_ready", in_ready, 8'h00);
    chk("t1 rst out_valid", out_valid, 0);
    chk("t1 rst out_data", out_data, 0);
    chk("t1 rst out_ch", out_ch, 0);
    chk("t1 rst out_last", out_last, 0);
    rst_n = 1'b1;
    clear_logs();
    @(posedge clk);
    #2;
    chk("t1 first grant", in_ready, 8'h01);
    wait_out("t1", 8, 60);
    for (int i = 0; i < N; i++) chk_beat("t1", i, i, 8'h10 + i, 1);
    chk("t1 gap", gap(0), 2);

    // 2: two-beat packet on ch3
    do_reset();
    push(3, 8'hA1, 1'b0);
    push(3, 8'hA2, 1'b1);
    wait_out("t2", 2, 30);
    chk_beat("t2", 0, 3, 8'hA1, 0);
    chk_beat("t2", 1, 3, 8'hA2, 1);
    chk("t2 gap", gap(0), 1);
    chk("t2 latency", (oq_cyc.size() > 0) ? oq_cyc[0] - acc_cyc[3] : -1, 1);
    chk("t2 idle in_ready", in_ready, 8'h00);
    chk("t2 idle out_valid", out_valid, 0);

    // 3: round robin over ch0/2/5 single-beat packets
    do_reset();
    push(0, 8'h01, 1'b1);
    push(0, 8'h02, 1'b1);
    push(2, 8'h21, 1'b1);
    push(2, 8'h22, 1'b1);
    push(5, 8'h51, 1'b1);
    push(5, 8'h52, 1'b1);
    wait_out("t3", 6, 60);
    chk_beat("t3", 0, 0, 8'h01, 1);
    chk_beat("t3", 1, 2, 8'h21, 1);
    chk_beat("t3", 2, 5, 8'h51, 1);
    chk_beat("t3", 3, 0, 8'h02, 1);
    chk_beat("t3", 4, 2, 8'h22, 1);
    chk_beat("t3", 5, 5, 8'h52, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("t3 gap%0d", i), gap(i), 2);

    // 4: downstream stall for 3 cycles mid-packet
    do_reset();
    push(6, 8'h61, 1'b0);
    push(6, 8'h62, 1'b0);
    push(6, 8'h63, 1'b1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b0;
    #1;
    chk("t4 stall in_ready", in_ready, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t4 hold valid%0d", i), out_valid, 1);
      chk($sformatf("t4 hold data%0d", i), out_data, 8'h61);
      chk($sformatf("t4 hold ch%0d", i), out_ch, 6);
      chk($sformatf("t4 hold rdy%0d", i), in_ready, 8'h00);
    end
    out_ready = 1'b1;
    wait_out("t4", 3, 30);
    chk_beat("t4", 0, 6, 8'h61, 0);
    chk_beat("t4", 1, 6, 8'h62, 0);
    chk_beat("t4", 2, 6, 8'h63, 1);

    // 5: grant stays on ch1 while ch0 requests, then ch0 wins by wrap
    do_reset();
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b0);
    push(1, 8'hB4, 1'b1);
    k = 0;
    while (acc_cnt[1] < 1 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    push(0, 8'hC0, 1'b1);
    wait_out("t5", 5, 40);
    chk_beat("t5", 0, 1, 8'hB1, 0);
    chk_beat("t5", 1, 1, 8'hB2, 0);
    chk_beat("t5", 2, 1, 8'hB3, 0);
    chk_beat("t5", 3, 1, 8'hB4, 1);
    chk_beat("t5", 4, 0, 8'hC0, 1);
    chk("t5 gap", gap(3), 2);

    // 6: async reset while ch4 beat 2 is being accepted
    do_reset();
    push(4, 8'h41, 1'b0);
    push(4, 8'h42, 1'b0);
    push(4, 8'h43, 1'b0);
    push(4, 8'h44, 1'b1);
    k = 0;
    while (acc_cnt[4] < 2 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    push(0, 8'h05, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst out_valid", out_valid, 0);
    chk("t6 rst out_data", out_data, 0);
    chk("t6 rst out_ch", out_ch, 0);
    chk("t6 rst in_ready", in_ready, 8'h00);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
    wait_out("t6", 4, 40);
    chk_beat("t6", 0, 0, 8'h05, 1);
    chk_beat("t6", 1, 4, 8'h42, 0);
    chk_beat("t6", 2, 4, 8'h43, 0);
    chk_beat("t6", 3, 4, 8'h44, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
